// File: rtl/neuron_classifier_pkg.sv
// Shared definitions for the perceptron classifier.
// Holds the default widths, the label encodings and the controller state type.
// Anything that produces or consumes weights or labels should import this
// package so that both sides agree on the encodings.
package neuron_classifier_pkg;

  localparam int XW_DEF = 7;   // sample feature width (signed)
  localparam int WW_DEF = 14;  // weight / bias width (signed)
  localparam int CW_DEF = 20;  // statistics counter width

  localparam logic [1:0] LBL_POS = 2'b01;  // +1
  localparam logic [1:0] LBL_NEG = 2'b11;  // -1

  typedef enum logic {
    NOWGT = 1'b0,  // no weights latched yet, samples refused
    RUN   = 1'b1   // weights valid, classifying
  } state_e;

  // A non-negative activation (zero included) classifies as +1.
  function automatic logic [1:0] sign_to_label(input logic neg);
    return neg ? LBL_NEG : LBL_POS;
  endfunction

endpackage

// File: rtl/neuron_classifier_if.sv
// Bus bundle for neuron_classifier: weight load port, sample input stream,
// result output stream and the statistics port.
//   master : the environment (weight source, sample source, result sink)
//   slave  : the classifier
interface neuron_classifier_if
  import neuron_classifier_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int WW = WW_DEF,
  parameter int CW = CW_DEF
);
  // weight load
  logic                 wLoad;
  logic                 wReady;
  logic [WW-1:0]        w1In;
  logic [WW-1:0]        w2In;
  logic [WW-1:0]        bIn;
  // sample stream
  logic                 inValid;
  logic                 inReady;
  logic [XW-1:0]        x1In;
  logic [XW-1:0]        x2In;
  logic [1:0]           tIn;
  // result stream
  logic                 outValid;
  logic                 outReady;
  logic [XW+WW:0]       yOut;
  logic [1:0]           label;
  logic                 mismatch;
  // statistics
  logic                 clrStats;
  logic [CW-1:0]        count;
  logic [CW-1:0]        errCount;

  modport master (
    output wLoad, w1In, w2In, bIn, inValid, x1In, x2In, tIn, outReady, clrStats,
    input  wReady, inReady, outValid, yOut, label, mismatch, count, errCount
  );

  modport slave (
    input  wLoad, w1In, w2In, bIn, inValid, x1In, x2In, tIn, outReady, clrStats,
    output wReady, inReady, outValid, yOut, label, mismatch, count, errCount
  );

endinterface

// File: rtl/neuron_sat_counter.sv
// Saturating up-counter used for the classifier statistics.
//   clk     : clock
//   rst_n   : asynchronous active-low reset (counter -> 0)
//   en_i    : increment request
//   clr_i   : synchronous clear, takes priority over en_i
//   count_o : current value, sticks at all-ones
module neuron_sat_counter
  import neuron_classifier_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/neuron_classifier.sv
// Two-input perceptron inference engine.
// Latches trained weights (w1, w2, b), then classifies a stream of
// (x1, x2, t) samples through a two-stage pipeline:
//   stage 1 : p1 = x1*w1, p2 = x2*w2, bias and target captured
//   stage 2 : y = p1 + p2 + b, label and mismatch derived from sign(y)
// Ports:
//   clk : clock
//   rst : asynchronous active-low reset
//   bus : neuron_classifier_if.slave (weights, samples, results, statistics)
// Weights can only be replaced while the pipeline is empty, so a result never
// mixes two weight sets. inReady and wReady are combinational; every other
// output is registered.
module neuron_classifier
  import neuron_classifier_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int WW = WW_DEF,
  parameter int CW = CW_DEF
) (
  input logic                clk,
  input logic                rst,
  neuron_classifier_if.slave bus
);

  localparam int PW = XW + WW;  // product width
  localparam int YW = PW + 1;   // activation width, holds the full sum

  state_e               state_q, state_d;
  logic signed [WW-1:0] w1_q, w2_q, b_q;

  logic                 s1_valid_q;
  logic signed [PW-1:0] p1_q, p2_q;
  logic signed [WW-1:0] b1_q;
  logic                 t1_neg_q;

  logic                 s2_valid_q;
  logic signed [YW-1:0] y_q;
  logic [1:0]           label_q;
  logic                 mismatch_q;

  logic                 s2_free, s1_free, s1_adv;
  logic                 in_ready, w_ready, in_acc, w_lat, out_hs;
  logic signed [PW-1:0] x1_ext, x2_ext, w1_ext, w2_ext, p1_d, p2_d;
  logic signed [YW-1:0] y_d;
  logic                 unused_t0;

  // Only the sign bit of the target matters.
  assign unused_t0 = bus.tIn[0];

  // ---------------- flow control ----------------
  assign out_hs   = s2_valid_q && bus.outReady;
  assign s2_free  = !s2_valid_q || bus.outReady;
  assign s1_adv   = s1_valid_q && s2_free;
  assign s1_free  = !s1_valid_q || s2_free;
  assign w_ready  = !s1_valid_q && !s2_valid_q;
  // wLoad blocks new samples so the pipeline drains ahead of a reload.
  assign in_ready = (state_q == RUN) && !bus.wLoad && s1_free;
  assign in_acc   = bus.inValid && in_ready;
  assign w_lat    = bus.wLoad && w_ready;

  assign bus.inReady = in_ready;
  assign bus.wReady  = w_ready;

  // ---------------- controller ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      NOWGT:   if (w_lat) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = NOWGT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= NOWGT;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w1_q <= '0;
      w2_q <= '0;
      b_q  <= '0;
    end else if (w_lat) begin
      w1_q <= bus.w1In;
      w2_q <= bus.w2In;
      b_q  <= bus.bIn;
    end
  end

  // ---------------- stage 1: products ----------------
  // Operands are widened to the product width first so the multiply is
  // exact at PW bits.
  assign x1_ext = {{WW{bus.x1In[XW-1]}}, bus.x1In};
  assign x2_ext = {{WW{bus.x2In[XW-1]}}, bus.x2In};
  assign w1_ext = {{XW{w1_q[WW-1]}}, w1_q};
  assign w2_ext = {{XW{w2_q[WW-1]}}, w2_q};
  assign p1_d   = x1_ext * w1_ext;
  assign p2_d   = x2_ext * w2_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
      b1_q       <= '0;
      t1_neg_q   <= 1'b0;
    end else begin
      if (s1_free) s1_valid_q <= in_acc;
      if (in_acc) begin
        p1_q     <= p1_d;
        p2_q     <= p2_d;
        b1_q     <= b_q;
        t1_neg_q <= bus.tIn[1];
      end
    end
  end

  // ---------------- stage 2: sum and classify ----------------
  assign y_d = {p1_q[PW-1], p1_q} + {p2_q[PW-1], p2_q}
             + {{(YW - WW){b1_q[WW-1]}}, b1_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      label_q    <= LBL_POS;
      mismatch_q <= 1'b0;
    end else begin
      if (s2_free) s2_valid_q <= s1_valid_q;
      // Data only moves on an advance, so a stalled result holds steady.
      if (s1_adv) begin
        y_q        <= y_d;
        label_q    <= sign_to_label(y_d[YW-1]);
        mismatch_q <= (y_d[YW-1] != t1_neg_q);
      end
    end
  end

  assign bus.outValid = s2_valid_q;
  assign bus.yOut     = y_q;
  assign bus.label    = label_q;
  assign bus.mismatch = mismatch_q;

  // ---------------- statistics ----------------
  neuron_sat_counter #(.CW(CW)) u_count (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (out_hs),
    .clr_i   (bus.clrStats),
    .count_o (bus.count)
  );

  neuron_sat_counter #(.CW(CW)) u_err_count (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (out_hs && mismatch_q),
    .clr_i   (bus.clrStats),
    .count_o (bus.errCount)
  );

endmodule

// File: tb/tb_neuron_classifier.sv
// Testbench for neuron_classifier: randomized and directed stimulus checked
// against an arithmetic reference model (expected-result queue, weight copy,
// saturating counter model).
module tb_neuron_classifier;
  import neuron_classifier_pkg::*;

  localparam int XW   = 7;
  localparam int WW   = 14;
  localparam int CW   = 20;
  localparam int SCW  = 3;
  localparam int YW   = XW + WW + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_classifier_if #(.XW(XW), .WW(WW), .CW(CW))  bus ();
  neuron_classifier_if #(.XW(XW), .WW(WW), .CW(SCW)) sbus ();

  neuron_classifier #(.XW(XW), .WW(WW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  neuron_classifier #(.XW(XW), .WW(WW), .CW(SCW)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  typedef struct {
    int         y;
    logic [1:0] lbl;
    logic       mm;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0, cyc = 0, outs = 0, last_lat = 0;
  int   mw1 = 0, mw2 = 0, mb = 0, mcnt = 0, merr = 0;
  bit   mrun = 0, last_in_hs = 0, last_wlat = 0, hold_pend = 0;
  logic [YW+2:0] hold_v;

  function automatic exp_t model(int x1, int x2, logic [1:0] t);
    exp_t e;
    e.y   = x1 * mw1 + x2 * mw2 + mb;
    e.lbl = (e.y < 0) ? 2'b11 : 2'b01;
    e.mm  = ((e.y < 0) != (t[1] == 1'b1));
    e.acc = cyc;
    return e;
  endfunction

  function automatic int rnd_x();
    return $signed($urandom_range(0, 127)) - 64;
  endfunction

  function automatic int rnd_w();
    return $signed($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic drive_sample(int x1, int x2, logic [1:0] t);
    bus.x1In    = XW'(x1);
    bus.x2In    = XW'(x2);
    bus.tIn     = t;
    bus.inValid = 1'b1;
  endtask

  // One clock cycle: observe handshakes just before the edge, update the
  // model, then check the counters just after the edge.
  task automatic cycle();
    exp_t e;
    bit in_hs, out_hs, exp_ir, exp_wr;
    logic [YW+2:0] got;
    #1;
    got = {bus.yOut, bus.label, bus.mismatch};
    if (hold_pend) begin
      checks++;
      if (!bus.outValid || got !== hold_v) begin
        failures++;
        $display("FAIL hold cyc=%0d got valid=%b data=%h required valid=1 data=%h",
                 cyc, bus.outValid, got, hold_v);
      end
    end
    exp_wr = (q.size() == 0);
    exp_ir = mrun && !bus.wLoad && (q.size() < 2 || bus.outReady);
    checks++;
    if (bus.wReady !== exp_wr || bus.inReady !== exp_ir) begin
      failures++;
      $display("FAIL flow cyc=%0d got wReady=%b inReady=%b required wReady=%b inReady=%b",
               cyc, bus.wReady, bus.inReady, exp_wr, exp_ir);
    end
    in_hs      = bus.inValid && bus.inReady;
    out_hs     = bus.outValid && bus.outReady;
    last_in_hs = in_hs;
    last_wlat  = bus.wLoad && bus.wReady;
    if (in_hs) q.push_back(model($signed(bus.x1In), $signed(bus.x2In), bus.tIn));
    if (last_wlat) begin
      mw1 = $signed(bus.w1In); mw2 = $signed(bus.w2In); mb = $signed(bus.bIn);
      mrun = 1'b1;
    end
    if (out_hs) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out cyc=%0d got y=%0d required no result", cyc, $signed(bus.yOut));
      end else begin
        e = q.pop_front();
        last_lat = cyc - e.acc;
        outs++;
        $display("out %0d cyc=%0d y=%0d label=%b mm=%b", outs, cyc, $signed(bus.yOut), bus.label, bus.mismatch);
        if (bus.yOut !== YW'(e.y) || bus.label !== e.lbl || bus.mismatch !== e.mm) begin
          failures++;
          $display("FAIL result cyc=%0d got y=%0d label=%b mm=%b required y=%0d label=%b mm=%b",
                   cyc, $signed(bus.yOut), bus.label, bus.mismatch, e.y, e.lbl, e.mm);
        end
        if (!bus.clrStats) begin
          if (mcnt < CMAX) mcnt++;
          if (e.mm && merr < CMAX) merr++;
        end
      end
    end
    if (bus.clrStats) begin mcnt = 0; merr = 0; end
    hold_pend = bus.outValid && !bus.outReady;
    hold_v    = got;
    @(posedge clk); #1;
    cyc++;
    checks++;
    if (bus.count !== CW'(mcnt) || bus.errCount !== CW'(merr)) begin
      failures++;
      $display("FAIL counters cyc=%0d got count=%0d err=%0d required count=%0d err=%0d",
               cyc, bus.count, bus.errCount, mcnt, merr);
    end
  endtask

  task automatic send(int x1, int x2, logic [1:0] t);
    drive_sample(x1, x2, t);
    last_in_hs = 0;
    for (int i = 0; i < 10 && !last_in_hs; i++) cycle();
    bus.inValid = 1'b0;
    checks++;
    if (!last_in_hs) begin
      failures++;
      $display("FAIL send_timeout cyc=%0d got accepted=0 required accepted=1", cyc);
    end
  endtask

  task automatic drain();
    bus.inValid = 1'b0; bus.wLoad = 1'b0; bus.outReady = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout cyc=%0d got pending=%0d required pending=0", cyc, q.size());
    end
  endtask

  task automatic load_weights(int w1, int w2, int b);
    bus.inValid = 1'b0; bus.outReady = 1'b1; bus.wLoad = 1'b1;
    bus.w1In = WW'(w1); bus.w2In = WW'(w2); bus.bIn = WW'(b);
    last_wlat = 0;
    for (int i = 0; i < 10 && !last_wlat; i++) cycle();
    bus.wLoad = 1'b0;
    checks++;
    if (!last_wlat) begin
      failures++;
      $display("FAIL wload_timeout cyc=%0d got latched=0 required latched=1", cyc);
    end
  endtask

  task automatic test_reset();
    drive_sample(rnd_x(), rnd_x(), 2'b01);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.inReady !== 1'b0 || bus.wReady !== 1'b1 || bus.outValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flow got inReady=%b wReady=%b outValid=%b required 0 1 0",
               bus.inReady, bus.wReady, bus.outValid);
    end
    checks++;
    if (bus.count !== '0 || bus.errCount !== '0 || bus.yOut !== '0 || bus.label !== 2'b01 || bus.mismatch !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got count=%0d err=%0d y=%0d label=%b mm=%b required 0 0 0 01 0",
               bus.count, bus.errCount, bus.yOut, bus.label, bus.mismatch);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_sample(rnd_x(), rnd_x(), 2'b11);
      cycle();
      checks++;
      if (bus.outValid !== 1'b0) begin
        failures++;
        $display("FAIL nowgt_out cyc=%0d got outValid=%b required 0", cyc, bus.outValid);
      end
    end
    bus.inValid = 1'b0;
  endtask

  task automatic test_basic();
    load_weights(2, 3, -1);
    send(4, -1, 2'b01);
    send(-4, 1, 2'b01);
    checks++;
    if (bus.outValid !== 1'b1 || bus.yOut !== YW'(4) || bus.label !== 2'b01 || bus.mismatch !== 1'b0) begin
      failures++;
      $display("FAIL basic_first got valid=%b y=%0d label=%b mm=%b required 1 4 01 0",
               bus.outValid, $signed(bus.yOut), bus.label, bus.mismatch);
    end
    cycle();
    checks++;
    if (last_lat != 2) begin
      failures++;
      $display("FAIL latency got %0d required 2", last_lat);
    end
    checks++;
    if (bus.yOut !== YW'(-6) || bus.label !== 2'b11 || bus.mismatch !== 1'b1) begin
      failures++;
      $display("FAIL basic_second got y=%0d label=%b mm=%b required -6 11 1",
               $signed(bus.yOut), bus.label, bus.mismatch);
    end
    cycle();
    checks++;
    if (bus.errCount !== CW'(1) || bus.count !== CW'(2)) begin
      failures++;
      $display("FAIL basic_counts got count=%0d err=%0d required 2 1", bus.count, bus.errCount);
    end
  endtask

  task automatic test_boundary();
    load_weights(1, 1, 0);
    send(3, -3, 2'b01);
    cycle();
    checks++;
    if (bus.yOut !== '0 || bus.label !== 2'b01 || bus.mismatch !== 1'b0) begin
      failures++;
      $display("FAIL zero_label got y=%0d label=%b mm=%b required 0 01 0",
               $signed(bus.yOut), bus.label, bus.mismatch);
    end
    drain();
    load_weights(-8192, -8192, -8192);
    send(-64, -64, 2'b01);
    cycle();
    checks++;
    if (bus.yOut !== YW'(1040384) || bus.label !== 2'b01) begin
      failures++;
      $display("FAIL extreme got y=%0d label=%b required 1040384 01", $signed(bus.yOut), bus.label);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int sent = 0;
    load_weights(rnd_w(), rnd_w(), rnd_w());
    bus.clrStats = 1'b1;
    cycle();
    bus.clrStats = 1'b0;
    for (int i = 0; i < 60 && (sent < 5 || q.size() != 0); i++) begin
      bus.outReady = pat[i % 4];
      if (sent < 5) drive_sample(rnd_x(), rnd_x(), 2'($urandom));
      else bus.inValid = 1'b0;
      cycle();
      if (last_in_hs) sent++;
    end
    bus.inValid = 1'b0;
    checks++;
    if (sent != 5 || q.size() != 0 || bus.count !== CW'(5)) begin
      failures++;
      $display("FAIL backpressure got sent=%0d pending=%0d count=%0d required 5 0 5",
               sent, q.size(), bus.count);
    end
  endtask

  task automatic test_reload();
    bus.outReady = 1'b0;
    send(rnd_x(), rnd_x(), 2'($urandom));
    send(rnd_x(), rnd_x(), 2'($urandom));
    checks++;
    if (bus.inReady !== 1'b0 || q.size() != 2) begin
      failures++;
      $display("FAIL full_pipe got inReady=%b inflight=%0d required 0 2", bus.inReady, q.size());
    end
    bus.wLoad = 1'b1;
    bus.w1In = WW'(rnd_w()); bus.w2In = WW'(rnd_w()); bus.bIn = WW'(rnd_w());
    drive_sample(rnd_x(), rnd_x(), 2'($urandom));
    cycle();
    cycle();
    bus.outReady = 1'b1;
    last_wlat = 0;
    for (int i = 0; i < 10 && !last_wlat; i++) cycle();
    bus.wLoad = 1'b0;
    checks++;
    if (!last_wlat || outs == 0) begin
      failures++;
      $display("FAIL reload_timeout got latched=%0d required 1", last_wlat);
    end
    cycle();
    for (int i = 0; i < 4; i++) send(rnd_x(), rnd_x(), 2'($urandom));
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bus.outReady = ($urandom_range(0, 9) < 7);
      bus.clrStats = ($urandom_range(0, 29) == 0);
      bus.wLoad    = ($urandom_range(0, 19) == 0);
      bus.w1In = WW'(rnd_w()); bus.w2In = WW'(rnd_w()); bus.bIn = WW'(rnd_w());
      if ($urandom_range(0, 9) < 7) drive_sample(rnd_x(), rnd_x(), 2'($urandom));
      else bus.inValid = 1'b0;
      cycle();
    end
    bus.clrStats = 1'b0;
    drain();
  endtask

  task automatic test_counters();
    load_weights(1, 1, 0);
    bus.outReady = 1'b0;
    send(5, 0, 2'b11);
    cycle();
    checks++;
    if (bus.outValid !== 1'b1 || bus.mismatch !== 1'b1) begin
      failures++;
      $display("FAIL clr_setup got valid=%b mm=%b required 1 1", bus.outValid, bus.mismatch);
    end
    bus.outReady = 1'b1;
    bus.clrStats = 1'b1;
    cycle();
    bus.clrStats = 1'b0;
    checks++;
    if (bus.count !== '0 || bus.errCount !== '0) begin
      failures++;
      $display("FAIL clr_priority got count=%0d err=%0d required 0 0", bus.count, bus.errCount);
    end
  endtask

  task automatic test_saturation();
    int nhs = 0, exp_c;
    sbus.wLoad = 1'b1; sbus.w1In = WW'(1); sbus.w2In = '0; sbus.bIn = '0;
    sbus.outReady = 1'b1;
    @(posedge clk); #1;
    sbus.wLoad = 1'b0;
    sbus.inValid = 1'b1; sbus.x1In = XW'(5); sbus.x2In = '0; sbus.tIn = 2'b11;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (sbus.outValid && sbus.outReady) begin
        nhs++;
        $display("sat out %0d y=%0d mm=%b", nhs, $signed(sbus.yOut), sbus.mismatch);
      end
      @(posedge clk); #1;
      exp_c = (nhs > 7) ? 7 : nhs;
      checks++;
      if (sbus.count !== SCW'(exp_c) || sbus.errCount !== SCW'(exp_c)) begin
        failures++;
        $display("FAIL saturation hs=%0d got count=%0d err=%0d required %0d %0d",
                 nhs, sbus.count, sbus.errCount, exp_c, exp_c);
      end
    end
    sbus.inValid = 1'b0;
    checks++;
    if (nhs < 9 || sbus.count !== 3'd7) begin
      failures++;
      $display("FAIL sat_final got hs=%0d count=%0d required >=9 7", nhs, sbus.count);
    end
  endtask

  task automatic test_async_reset();
    bus.outReady = 1'b0;
    send(rnd_x(), rnd_x(), 2'b01);
    cycle();
    checks++;
    if (bus.outValid !== 1'b1) begin
      failures++;
      $display("FAIL ar_setup got outValid=%b required 1", bus.outValid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.outValid !== 1'b0 || bus.wReady !== 1'b1 || bus.inReady !== 1'b0 ||
        bus.count !== '0 || bus.yOut !== '0 || bus.label !== 2'b01) begin
      failures++;
      $display("FAIL async_reset got valid=%b wReady=%b inReady=%b count=%0d y=%0d label=%b required 0 1 0 0 0 01",
               bus.outValid, bus.wReady, bus.inReady, bus.count, $signed(bus.yOut), bus.label);
    end
    q.delete();
    mcnt = 0; merr = 0; mw1 = 0; mw2 = 0; mb = 0; mrun = 0; hold_pend = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_sample(rnd_x(), rnd_x(), 2'b01);
      cycle();
    end
    bus.inValid = 1'b0;
  endtask

  initial begin
    bus.wLoad = 0; bus.w1In = '0; bus.w2In = '0; bus.bIn = '0;
    bus.inValid = 0; bus.x1In = '0; bus.x2In = '0; bus.tIn = '0;
    bus.outReady = 1; bus.clrStats = 0;
    sbus.wLoad = 0; sbus.w1In = '0; sbus.w2In = '0; sbus.bIn = '0;
    sbus.inValid = 0; sbus.x1In = '0; sbus.x2In = '0; sbus.tIn = '0;
    sbus.outReady = 1; sbus.clrStats = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_reload();
    test_random();
    test_counters();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
